// File: rtl/bure_mem_arbiter.sv
// Bure pipeline memory arbiter: serialises fetch and data requests onto a single
// memory port, one outstanding transaction, with fetch anti-starvation and a response timeout.
module bure_mem_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_ireq_valid,
  output logic                    o_ireq_ready,
  input  logic [ADDR_WIDTH-1:0]   i_ireq_addr,
  output logic                    o_irsp_valid,
  output logic [DATA_WIDTH-1:0]   o_irsp_rdata,
  output logic                    o_irsp_err,
  input  logic                    i_dreq_valid,
  output logic                    o_dreq_ready,
  input  logic [ADDR_WIDTH-1:0]   i_dreq_addr,
  input  logic                    i_dreq_we,
  input  logic [DATA_WIDTH/8-1:0] i_dreq_be,
  input  logic [DATA_WIDTH-1:0]   i_dreq_wdata,
  output logic                    o_drsp_valid,
  output logic [DATA_WIDTH-1:0]   o_drsp_rdata,
  output logic                    o_drsp_err,
  output logic                    o_mreq_valid,
  input  logic                    i_mreq_ready,
  output logic [ADDR_WIDTH-1:0]   o_mreq_addr,
  output logic                    o_mreq_we,
  output logic [DATA_WIDTH/8-1:0] o_mreq_be,
  output logic [DATA_WIDTH-1:0]   o_mreq_wdata,
  input  logic                    i_mrsp_valid,
  input  logic [DATA_WIDTH-1:0]   i_mrsp_rdata,
  input  logic                    i_mrsp_err,
  output logic                    o_busy
);
  localparam int          BE_WIDTH   = DATA_WIDTH / 8;
  localparam logic [7:0]  STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e                state_q, state_d;
  logic [7:0]            starve_cnt_q, starve_cnt_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;
  logic                  owner_data_q, owner_data_d;
  logic [ADDR_WIDTH-1:0] mreq_addr_q, mreq_addr_d;
  logic                  mreq_we_q, mreq_we_d;
  logic [BE_WIDTH-1:0]   mreq_be_q, mreq_be_d;
  logic [DATA_WIDTH-1:0] mreq_wdata_q, mreq_wdata_d;
  logic                  irsp_valid_q, irsp_valid_d, irsp_err_q, irsp_err_d;
  logic [DATA_WIDTH-1:0] irsp_rdata_q, irsp_rdata_d;
  logic                  drsp_valid_q, drsp_valid_d, drsp_err_q, drsp_err_d;
  logic [DATA_WIDTH-1:0] drsp_rdata_q, drsp_rdata_d;
  logic                  grant_i, grant_d;

  // Data wins until it has taken STARVE_LIMIT grants in a row over a waiting fetch.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == ST_IDLE && !i_rst) begin
      if (i_dreq_valid && starve_cnt_q < STARVE_LIM) grant_d = 1'b1;
      else if (i_ireq_valid)                         grant_i = 1'b1;
      else if (i_dreq_valid)                         grant_d = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the
    // case can leave one unassigned and infer a latch.
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    owner_data_d = owner_data_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_we_d    = mreq_we_q;
    mreq_be_d    = mreq_be_q;
    mreq_wdata_d = mreq_wdata_q;
    irsp_valid_d = 1'b0;
    irsp_err_d   = 1'b0;
    irsp_rdata_d = '0;
    drsp_valid_d = 1'b0;
    drsp_err_d   = 1'b0;
    drsp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d      = ST_REQ;
          owner_data_d = 1'b1;
          mreq_addr_d  = i_dreq_addr;
          mreq_we_d    = i_dreq_we;
          mreq_be_d    = i_dreq_be;
          mreq_wdata_d = i_dreq_wdata;
          if (i_ireq_valid && starve_cnt_q != 8'hFF) starve_cnt_d = starve_cnt_q + 8'd1;
        end else if (grant_i) begin
          state_d      = ST_REQ;
          owner_data_d = 1'b0;
          mreq_addr_d  = i_ireq_addr;
          mreq_we_d    = 1'b0;
          mreq_be_d    = '1;
          mreq_wdata_d = '0;
          starve_cnt_d = 8'd0;
        end
      end
      ST_REQ: begin
        if (i_mreq_ready) begin
          state_d   = ST_WAIT;
          tmo_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        // A real response on the terminal-count cycle takes precedence over the timeout.
        if (i_mrsp_valid || tmo_cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          if (owner_data_q) begin
            drsp_valid_d = 1'b1;
            drsp_rdata_d = i_mrsp_valid ? i_mrsp_rdata : '0;
            drsp_err_d   = i_mrsp_valid ? i_mrsp_err : 1'b1;
          end else begin
            irsp_valid_d = 1'b1;
            irsp_rdata_d = i_mrsp_valid ? i_mrsp_rdata : '0;
            irsp_err_d   = i_mrsp_valid ? i_mrsp_err : 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values no matter how the statements are ordered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      owner_data_q <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_we_q    <= 1'b0;
      mreq_be_q    <= '0;
      mreq_wdata_q <= '0;
      irsp_valid_q <= 1'b0;
      irsp_err_q   <= 1'b0;
      irsp_rdata_q <= '0;
      drsp_valid_q <= 1'b0;
      drsp_err_q   <= 1'b0;
      drsp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      owner_data_q <= owner_data_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_we_q    <= mreq_we_d;
      mreq_be_q    <= mreq_be_d;
      mreq_wdata_q <= mreq_wdata_d;
      irsp_valid_q <= irsp_valid_d;
      irsp_err_q   <= irsp_err_d;
      irsp_rdata_q <= irsp_rdata_d;
      drsp_valid_q <= drsp_valid_d;
      drsp_err_q   <= drsp_err_d;
      drsp_rdata_q <= drsp_rdata_d;
    end
  end

  assign o_ireq_ready = grant_i;
  assign o_dreq_ready = grant_d;
  assign o_mreq_valid = (state_q == ST_REQ);
  assign o_mreq_addr  = mreq_addr_q;
  assign o_mreq_we    = mreq_we_q;
  assign o_mreq_be    = mreq_be_q;
  assign o_mreq_wdata = mreq_wdata_q;
  assign o_irsp_valid = irsp_valid_q;
  assign o_irsp_rdata = irsp_rdata_q;
  assign o_irsp_err   = irsp_err_q;
  assign o_drsp_valid = drsp_valid_q;
  assign o_drsp_rdata = drsp_rdata_q;
  assign o_drsp_err   = drsp_err_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bure_mem_arbiter.sv
// Self-checking bench for bure_mem_arbiter: grant-order vector table, directed
// corner-case sequences, and a randomized run against a transaction-timeline model.
module tb_bure_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int SL = 4;
  localparam int TO = 64;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_ireq_valid, o_ireq_ready;
  logic [AW-1:0] i_ireq_addr;
  logic          o_irsp_valid, o_irsp_err;
  logic [DW-1:0] o_irsp_rdata;
  logic          i_dreq_valid, o_dreq_ready, i_dreq_we;
  logic [AW-1:0] i_dreq_addr;
  logic [BW-1:0] i_dreq_be;
  logic [DW-1:0] i_dreq_wdata;
  logic          o_drsp_valid, o_drsp_err;
  logic [DW-1:0] o_drsp_rdata;
  logic          o_mreq_valid, i_mreq_ready, o_mreq_we;
  logic [AW-1:0] o_mreq_addr;
  logic [BW-1:0] o_mreq_be;
  logic [DW-1:0] o_mreq_wdata;
  logic          i_mrsp_valid, i_mrsp_err;
  logic [DW-1:0] i_mrsp_rdata;
  logic          o_busy;

  bure_mem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ireq_valid(i_ireq_valid), .o_ireq_ready(o_ireq_ready), .i_ireq_addr(i_ireq_addr),
    .o_irsp_valid(o_irsp_valid), .o_irsp_rdata(o_irsp_rdata), .o_irsp_err(o_irsp_err),
    .i_dreq_valid(i_dreq_valid), .o_dreq_ready(o_dreq_ready), .i_dreq_addr(i_dreq_addr),
    .i_dreq_we(i_dreq_we), .i_dreq_be(i_dreq_be), .i_dreq_wdata(i_dreq_wdata),
    .o_drsp_valid(o_drsp_valid), .o_drsp_rdata(o_drsp_rdata), .o_drsp_err(o_drsp_err),
    .o_mreq_valid(o_mreq_valid), .i_mreq_ready(i_mreq_ready), .o_mreq_addr(o_mreq_addr),
    .o_mreq_we(o_mreq_we), .o_mreq_be(o_mreq_be), .o_mreq_wdata(o_mreq_wdata),
    .i_mrsp_valid(i_mrsp_valid), .i_mrsp_rdata(i_mrsp_rdata), .i_mrsp_err(i_mrsp_err),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic iv;
    logic dv;
    logic exp_ir;
    logic exp_dr;
  } vec_t;
  vec_t vecs[26];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled one step later.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_ireq_valid = 0; i_ireq_addr = '0;
    i_dreq_valid = 0; i_dreq_addr = '0; i_dreq_we = 0; i_dreq_be = '0; i_dreq_wdata = '0;
    i_mreq_ready = 0; i_mrsp_valid = 0; i_mrsp_rdata = '0; i_mrsp_err = 0;
  endtask

  function automatic logic [3:0] rsp_flags();
    return {o_irsp_valid, o_irsp_err, o_drsp_valid, o_drsp_err};
  endfunction

  // Accept one request (cycle 0), hand it to memory (cycle 1); returns in the first WAIT cycle.
  task automatic start_txn(input string tag, input bit is_d, input logic [AW-1:0] addr);
    i_ireq_valid = !is_d; i_ireq_addr = addr;
    i_dreq_valid = is_d;  i_dreq_addr = addr; i_dreq_we = 0; i_dreq_be = '1; i_dreq_wdata = '0;
    settle();
    check({tag, " accept"}, 64'({o_ireq_ready, o_dreq_ready}), 64'({!is_d, is_d}));
    cyc();
    i_ireq_valid = 0; i_dreq_valid = 0; i_mreq_ready = 1;
    cyc();
    i_mreq_ready = 0;
  endtask

  // Random-phase model state: a transaction is described by the cycles at which things happen.
  int          n, t_acc, ready_at, rsp_at, out_at, w, starve, waited, cnt;
  bit          busy_m, own_d, pend_i, pend_d, free, gi, gd, exp_iv, exp_dv, exp_mv, seen;
  logic [AW-1:0] ia, da, e_addr;
  logic [BW-1:0] dbe, e_be;
  logic [DW-1:0] dwd, e_wdata, e_rdata;
  logic          dwe, e_we, e_err;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0};
    vecs[1]  = '{1, 0, 1, 0};
    vecs[2]  = '{0, 1, 0, 1};
    vecs[3]  = '{1, 1, 0, 1};
    vecs[4]  = '{1, 1, 0, 1};
    vecs[5]  = '{1, 1, 0, 1};
    vecs[6]  = '{1, 1, 0, 1};
    vecs[7]  = '{1, 1, 1, 0};
    vecs[8]  = '{0, 1, 0, 1};
    vecs[9]  = '{1, 1, 0, 1};
    vecs[10] = '{1, 1, 0, 1};
    vecs[11] = '{1, 1, 0, 1};
    vecs[12] = '{1, 1, 0, 1};
    vecs[13] = '{0, 1, 0, 1};
    vecs[14] = '{1, 1, 1, 0};
    vecs[15] = '{0, 0, 0, 0};
    for (int i = 16; i < 26; i++) vecs[i] = '{1, 1, (i == 20 || i == 25), !(i == 20 || i == 25)};

    // Reset with both requesters asserting: every output must be 0.
    clear_inputs();
    i_ireq_valid = 1; i_dreq_valid = 1;
    #2;
    check("reset ready", 64'({o_ireq_ready, o_dreq_ready}), 64'(0));
    check("reset busy/mreq", 64'({o_busy, o_mreq_valid, o_mreq_we}), 64'(0));
    check("reset rsp flags", 64'(rsp_flags()), 64'(0));
    check("reset mreq addr", 64'(o_mreq_addr), 64'(0));
    check("reset rdata", {o_irsp_rdata, o_drsp_rdata}, 64'(0));
    cyc(); cyc();
    i_rst = 0;
    clear_inputs();
    cyc();

    // A: single fetch with immediate memory, response exactly at cycle 3.
    i_ireq_valid = 1; i_ireq_addr = 32'h100; settle();
    check("A ready", 64'({o_ireq_ready, o_dreq_ready}), 64'(2'b10));
    cyc(); i_ireq_valid = 0; i_mreq_ready = 1; settle();
    check("A mreq_valid", 64'(o_mreq_valid), 64'(1));
    check("A mreq_addr", 64'(o_mreq_addr), 64'(32'h100));
    check("A mreq we/be/wdata", 64'({o_mreq_we, o_mreq_be, o_mreq_wdata}), 64'({1'b0, 4'hF, 32'h0}));
    check("A rsp c1", 64'(rsp_flags()), 64'(0));
    cyc(); i_mreq_ready = 0; i_mrsp_valid = 1; i_mrsp_rdata = 32'hDEADBEEF; settle();
    check("A rsp c2", 64'(rsp_flags()), 64'(0));
    cyc(); i_mrsp_valid = 0; i_mrsp_rdata = '0; settle();
    check("A rsp c3", 64'(rsp_flags()), 64'(4'b1000));
    check("A rdata", 64'(o_irsp_rdata), 64'(32'hDEADBEEF));
    check("A drsp_rdata", 64'(o_drsp_rdata), 64'(0));
    check("A busy c3", 64'(o_busy), 64'(0));
    cyc(); settle();
    check("A rsp c4", 64'(rsp_flags()), 64'(0));
    check("A rdata c4", 64'(o_irsp_rdata), 64'(0));
    cyc();

    // B: data write with memory stalling five cycles; command must hold.
    i_dreq_valid = 1; i_dreq_addr = 32'h200; i_dreq_we = 1; i_dreq_be = 4'h3; i_dreq_wdata = 32'h1234;
    settle();
    check("B ready", 64'({o_ireq_ready, o_dreq_ready}), 64'(2'b01));
    cyc();
    i_dreq_valid = 0; i_dreq_addr = 32'hFFFF; i_dreq_we = 0; i_dreq_be = 4'hC; i_dreq_wdata = 32'hFFFF;
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      i_mreq_ready = (k == 6); settle();
      check($sformatf("B REQ%0d valid/busy", k), 64'({o_mreq_valid, o_busy}), 64'(2'b11));
      check($sformatf("B REQ%0d addr", k), 64'(o_mreq_addr), 64'(32'h200));
      check($sformatf("B REQ%0d cmd", k), 64'({o_mreq_we, o_mreq_be, o_mreq_wdata}), 64'({1'b1, 4'h3, 32'h1234}));
      cnt += 32'(o_drsp_valid);
      cyc();
    end
    i_mreq_ready = 0; i_mrsp_valid = 1; i_mrsp_rdata = 32'h0; settle();
    check("B WAIT busy/mreq", 64'({o_busy, o_mreq_valid}), 64'(2'b10));
    cnt += 32'(o_drsp_valid);
    cyc(); i_mrsp_valid = 0;
    for (int k = 0; k < 4; k++) begin
      settle();
      cnt += 32'(o_drsp_valid);
      check($sformatf("B irsp quiet %0d", k), 64'(o_irsp_valid), 64'(0));
      cyc();
    end
    check("B drsp count", 64'(cnt), 64'(1));

    // C: dead memory, timeout error 64 cycles after entering WAIT, then a late response ignored.
    start_txn("C", 1, 32'h300);
    waited = 0; seen = 0;
    while (!seen && waited < 200) begin
      settle();
      if (o_drsp_valid) seen = 1;
      else begin cyc(); waited++; end
    end
    check("C timeout seen", 64'(seen), 64'(1));
    check("C timeout latency", 64'(waited), 64'(TO));
    check("C timeout err", 64'(rsp_flags()), 64'(4'b0011));
    check("C timeout rdata", 64'(o_drsp_rdata), 64'(0));
    cyc(); i_mrsp_valid = 1; i_mrsp_rdata = 32'hBAD0BAD0; i_mrsp_err = 1;
    cyc(); i_mrsp_valid = 0; i_mrsp_err = 0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); cnt += 32'(o_drsp_valid | o_irsp_valid); cyc();
    end
    check("C late rsp ignored", 64'(cnt), 64'(0));

    // D1: memory error reaches the fetch owner.
    start_txn("D1", 0, 32'h340);
    i_mrsp_valid = 1; i_mrsp_rdata = 32'h77; i_mrsp_err = 1;
    cyc(); i_mrsp_valid = 0; i_mrsp_err = 0; settle();
    check("D1 err rsp", 64'(rsp_flags()), 64'(4'b1100));
    check("D1 rdata", 64'(o_irsp_rdata), 64'(32'h77));
    cyc();

    // D2: response on the terminal-count cycle delivers real data, no timeout.
    start_txn("D2", 0, 32'h380);
    cnt = 0;
    for (int j = 0; j < TO - 1; j++) begin
      settle(); cnt += 32'(o_irsp_valid | o_drsp_valid); cyc();
    end
    check("D2 quiet before tc", 64'(cnt), 64'(0));
    i_mrsp_valid = 1; i_mrsp_rdata = 32'hCAFEF00D;
    cyc(); i_mrsp_valid = 0; settle();
    check("D2 tc rsp", 64'(rsp_flags()), 64'(4'b1000));
    check("D2 tc rdata", 64'(o_irsp_rdata), 64'(32'hCAFEF00D));
    cyc(); settle();
    check("D2 no extra rsp", 64'(rsp_flags()), 64'(0));
    cyc();

    // E: reset in WAIT aborts silently; a fresh fetch then completes.
    start_txn("E", 0, 32'h400);
    i_ireq_valid = 1; i_dreq_valid = 1;
    #2 i_rst = 1;
    #1;
    check("E reset ready", 64'({o_ireq_ready, o_dreq_ready}), 64'(0));
    check("E reset busy/mreq", 64'({o_busy, o_mreq_valid}), 64'(0));
    check("E reset mreq_addr", 64'(o_mreq_addr), 64'(0));
    check("E reset rsp", 64'(rsp_flags()), 64'(0));
    cyc(); cyc();
    clear_inputs();
    i_rst = 0;
    i_mrsp_valid = 1; i_mrsp_rdata = 32'h5555; settle();
    check("E idle after reset", 64'(o_busy), 64'(0));
    cyc(); i_mrsp_valid = 0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      settle(); cnt += 32'(o_irsp_valid | o_drsp_valid); cyc();
    end
    check("E no stale rsp", 64'(cnt), 64'(0));
    start_txn("E2", 0, 32'h500);
    i_mrsp_valid = 1; i_mrsp_rdata = 32'h600DF00D;
    cyc(); i_mrsp_valid = 0; settle();
    check("E2 rsp", 64'(rsp_flags()), 64'(4'b1000));
    check("E2 rdata", 64'(o_irsp_rdata), 64'(32'h600DF00D));
    cyc();

    // Grant-rule vector table; each granted request runs to completion with immediate memory.
    for (int i = 0; i < 26; i++) begin
      i_ireq_valid = vecs[i].iv; i_ireq_addr = 32'h1000 + 32'(i * 4);
      i_dreq_valid = vecs[i].dv; i_dreq_addr = 32'h2000 + 32'(i * 4);
      i_dreq_we = 1'(i & 1); i_dreq_be = 4'hF; i_dreq_wdata = 32'h5A00_0000 + 32'(i);
      settle();
      check($sformatf("vec%0d ready", i), 64'({o_ireq_ready, o_dreq_ready}),
            64'({vecs[i].exp_ir, vecs[i].exp_dr}));
      cyc();
      i_ireq_valid = 0; i_dreq_valid = 0;
      if (vecs[i].exp_ir || vecs[i].exp_dr) begin
        i_mreq_ready = 1; settle();
        check($sformatf("vec%0d mreq_valid", i), 64'(o_mreq_valid), 64'(1));
        check($sformatf("vec%0d mreq_addr", i), 64'(o_mreq_addr),
              64'(vecs[i].exp_dr ? 32'h2000 + 32'(i * 4) : 32'h1000 + 32'(i * 4)));
        check($sformatf("vec%0d mreq_we", i), 64'(o_mreq_we), 64'(vecs[i].exp_dr && (i & 1) == 1));
        cyc(); i_mreq_ready = 0; i_mrsp_valid = 1; i_mrsp_rdata = 32'hA500_0000 + 32'(i);
        cyc(); i_mrsp_valid = 0; settle();
        check($sformatf("vec%0d rsp", i), 64'(rsp_flags()),
              64'({vecs[i].exp_ir, 1'b0, vecs[i].exp_dr, 1'b0}));
        check($sformatf("vec%0d rdata", i), {o_irsp_rdata, o_drsp_rdata},
              {vecs[i].exp_ir ? 32'hA500_0000 + 32'(i) : 32'h0,
               vecs[i].exp_dr ? 32'hA500_0000 + 32'(i) : 32'h0});
      end
    end
    clear_inputs();
    cyc();

    // Randomized run: requesters hold valid until accepted; memory stalls, responds late,
    // times out, or pulses stray responses while no answer is due.
    busy_m = 0; pend_i = 0; pend_d = 0; starve = 0; out_at = -1; rsp_at = -1; ready_at = -1; t_acc = -1;
    own_d = 0; e_addr = '0; e_we = 0; e_be = '0; e_wdata = '0; e_rdata = '0; e_err = 0;
    for (n = 0; n < 4000; n++) begin
      if (!pend_i && $urandom_range(2) == 0) begin pend_i = 1; ia = $urandom; end
      if (!pend_d && $urandom_range(2) == 0) begin
        pend_d = 1; da = $urandom; dwe = 1'($urandom); dbe = 4'($urandom); dwd = $urandom;
      end
      i_ireq_valid = pend_i; i_ireq_addr = ia;
      i_dreq_valid = pend_d; i_dreq_addr = da; i_dreq_we = dwe; i_dreq_be = dbe; i_dreq_wdata = dwd;
      i_mreq_ready = busy_m && n == ready_at;
      if (busy_m && n == rsp_at) begin
        i_mrsp_valid = 1; i_mrsp_rdata = e_rdata; i_mrsp_err = e_err;
      end else if ((!busy_m || n <= ready_at) && $urandom_range(7) == 0) begin
        i_mrsp_valid = 1; i_mrsp_rdata = $urandom; i_mrsp_err = 1'($urandom);
      end else begin
        i_mrsp_valid = 0; i_mrsp_rdata = $urandom; i_mrsp_err = 0;
      end
      settle();

      free = !busy_m || n == out_at;
      gi = 0; gd = 0;
      if (free) begin
        if (pend_d && starve < SL) gd = 1;
        else if (pend_i)           gi = 1;
        else if (pend_d)           gd = 1;
      end
      check($sformatf("rnd%0d ready", n), 64'({o_ireq_ready, o_dreq_ready}), 64'({gi, gd}));
      check($sformatf("rnd%0d busy", n), 64'(o_busy), 64'(!free));
      exp_mv = busy_m && n > t_acc && n <= ready_at;
      check($sformatf("rnd%0d mreq_valid", n), 64'(o_mreq_valid), 64'(exp_mv));
      if (exp_mv) begin
        check($sformatf("rnd%0d mreq_addr", n), 64'(o_mreq_addr), 64'(e_addr));
        check($sformatf("rnd%0d mreq_cmd", n), 64'({o_mreq_we, o_mreq_be, o_mreq_wdata}),
              64'({e_we, e_be, e_wdata}));
      end
      exp_iv = busy_m && n == out_at && !own_d;
      exp_dv = busy_m && n == out_at && own_d;
      check($sformatf("rnd%0d rsp", n), 64'(rsp_flags()),
            64'({exp_iv, exp_iv & e_err, exp_dv, exp_dv & e_err}));
      check($sformatf("rnd%0d rdata", n), {o_irsp_rdata, o_drsp_rdata},
            {exp_iv ? e_rdata : 32'h0, exp_dv ? e_rdata : 32'h0});

      if (busy_m && n == out_at) busy_m = 0;
      if (gi || gd) begin
        busy_m = 1; own_d = gd; t_acc = n;
        ready_at = n + 1 + int'($urandom_range(3));
        if (gd) begin
          e_addr = da; e_we = dwe; e_be = dbe; e_wdata = dwd; pend_d = 0;
          if (pend_i && starve < 255) starve++;
        end else begin
          e_addr = ia; e_we = 0; e_be = '1; e_wdata = '0; pend_i = 0;
          starve = 0;
        end
        w = ($urandom_range(9) == 0) ? 70 : int'($urandom_range(5));
        e_rdata = $urandom; e_err = 1'($urandom);
        if (w <= TO - 1) begin
          rsp_at = ready_at + 1 + w; out_at = rsp_at + 1;
        end else begin
          rsp_at = -1; out_at = ready_at + 1 + TO; e_rdata = '0; e_err = 1;
        end
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
